// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d datapath blocks.
// Holds the serialiser state encoding and a constant-evaluable clog2.
package cnn1d_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } serialiser_state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/layer_serialiser.sv
// Captures a full vector of NUM_INPUTS lane words and emits them one per
// handshake, lane 0 first, with back-to-back capture on the last word.
module layer_serialiser
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 32,
    localparam int INDEX_WIDTH = (clog2(NUM_INPUTS) < 1) ? 1 : clog2(NUM_INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   serialiser_ready_in,
    input  logic [NUM_INPUTS-1:0]  serialiser_valid_in,
    input  logic [DATA_WIDTH-1:0]  serialiser_data_in [0:NUM_INPUTS-1],
    input  logic                   serialiser_ready_out,
    output logic                   serialiser_valid_out,
    output logic [DATA_WIDTH-1:0]  serialiser_data_out,
    output logic                   serialiser_last_out,
    output logic [INDEX_WIDTH-1:0] serialiser_index_out
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

    serialiser_state_t      r_state;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [DATA_WIDTH-1:0]  r_buf [0:NUM_INPUTS-1];

    serialiser_state_t      w_state_next;
    logic [INDEX_WIDTH-1:0] w_index_next;
    logic                   w_last;
    logic                   w_ready_in;
    logic                   w_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_index <= '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            if (w_capture) begin
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    r_buf[i] <= serialiser_data_in[i];
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_last       = (r_index == LAST_IDX);
        w_ready_in   = (r_state == IDLE) ||
                       ((r_state == SEND) && w_last && serialiser_ready_out);
        w_capture    = w_ready_in && (&serialiser_valid_in);

        // A capture can only coincide with the last-word handshake, so it takes priority.
        if (w_capture) begin
            w_state_next = SEND;
            w_index_next = '0;
        end else if ((r_state == SEND) && serialiser_ready_out) begin
            if (w_last) begin
                w_state_next = IDLE;
            end else begin
                w_index_next = r_index + INDEX_WIDTH'(1);
            end
        end
    end

    assign serialiser_ready_in  = w_ready_in;
    assign serialiser_valid_out = (r_state == SEND);
    assign serialiser_last_out  = (r_state == SEND) && w_last;
    assign serialiser_data_out  = r_buf[r_index];
    assign serialiser_index_out = r_index;

endmodule

// File: tb/tb_layer_serialiser.sv
// Directed scoreboard bench for layer_serialiser with four 32-bit lanes.
module tb_layer_serialiser;

    localparam int DW = 32;
    localparam int NI = 4;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  index;
        logic        last;
    } word_t;

    logic          clk;
    logic          rst;
    logic          ready_in;
    logic [NI-1:0] valid_in;
    logic [DW-1:0] data_in [0:NI-1];
    logic          ready_out;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          last_out;
    logic [1:0]    index_out;

    word_t exp_q[$];
    int    total;
    int    bad;

    layer_serialiser #(
        .DATA_WIDTH(DW),
        .NUM_INPUTS(NI)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .serialiser_ready_in  (ready_in),
        .serialiser_valid_in  (valid_in),
        .serialiser_data_in   (data_in),
        .serialiser_ready_out (ready_out),
        .serialiser_valid_out (valid_out),
        .serialiser_data_out  (data_out),
        .serialiser_last_out  (last_out),
        .serialiser_index_out (index_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample at negedge; a word seen with valid&ready is consumed at the next posedge.
    task automatic cycle();
        word_t e;
        @(negedge clk);
        if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {31'b0, valid_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", data_out, e.data);
                chk("word_index", {30'b0, index_out}, {30'b0, e.index});
                chk("word_last", {31'b0, last_out}, {31'b0, e.last});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3, input bit push);
        word_t w;
        data_in[0] = d0;
        data_in[1] = d1;
        data_in[2] = d2;
        data_in[3] = d3;
        valid_in   = 4'b1111;
        if (push) begin
            for (int i = 0; i < NI; i++) begin
                w.data  = data_in[i];
                w.index = 2'(i);
                w.last  = (i == NI - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            cycle();
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        valid_in  = '0;
        ready_out = 1'b1;
        for (int i = 0; i < NI; i++) data_in[i] = '0;

        repeat (2) cycle();
        rst = 1'b0;
        chk("rst_ready_in", {31'b0, ready_in}, 32'd1);
        chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
        chk("rst_last_out", {31'b0, last_out}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_index_out", {30'b0, index_out}, 32'd0);

        // Basic vector, ready_out high throughout.
        load(32'h10, 32'h20, 32'h30, 32'h40, 1'b1);
        cycle();
        valid_in = '0;
        chk("lat1_valid", {31'b0, valid_out}, 32'd1);
        chk("lat1_data", data_out, 32'h10);
        drain();
        chk("after_vec_valid", {31'b0, valid_out}, 32'd0);
        chk("after_vec_ready_in", {31'b0, ready_in}, 32'd1);

        // Partial valid is ignored.
        data_in[0] = 32'hBAD0;
        data_in[1] = 32'hBAD1;
        data_in[2] = 32'hBAD2;
        data_in[3] = 32'hBAD3;
        valid_in   = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("partial_ready_in", {31'b0, ready_in}, 32'd1);
            chk("partial_valid_out", {31'b0, valid_out}, 32'd0);
        end
        valid_in = '0;

        // Downstream stall while 0x20 is presented.
        load(32'h10, 32'h20, 32'h30, 32'h40, 1'b1);
        cycle();
        valid_in = '0;
        cycle();
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", data_out, 32'h20);
            chk("stall_index", {30'b0, index_out}, 32'd1);
            chk("stall_valid", {31'b0, valid_out}, 32'd1);
            cycle();
        end
        chk("stall_end_data", data_out, 32'h20);
        ready_out = 1'b1;
        drain();

        // Back-to-back capture on the last-word handshake.
        load(32'h10, 32'h20, 32'h30, 32'h40, 1'b1);
        cycle();
        valid_in = '0;
        repeat (3) cycle();
        chk("b2b_last_shown", data_out, 32'h40);
        chk("b2b_last_flag", {31'b0, last_out}, 32'd1);
        chk("b2b_ready_in", {31'b0, ready_in}, 32'd1);
        load(32'hA1, 32'hA2, 32'hA3, 32'hA4, 1'b1);
        cycle();
        valid_in = '0;
        chk("b2b_no_gap_valid", {31'b0, valid_out}, 32'd1);
        chk("b2b_no_gap_data", data_out, 32'hA1);
        chk("b2b_no_gap_index", {30'b0, index_out}, 32'd0);
        drain();

        // Reset after 0x20 is accepted discards 0x30 and 0x40.
        load(32'h10, 32'h20, 32'h30, 32'h40, 1'b0);
        begin
            word_t w;
            w.data = 32'h10; w.index = 2'd0; w.last = 1'b0; exp_q.push_back(w);
            w.data = 32'h20; w.index = 2'd1; w.last = 1'b0; exp_q.push_back(w);
        end
        cycle();
        valid_in = '0;
        repeat (2) cycle();
        chk("pre_rst_sb_empty", exp_q.size(), 32'd0);
        rst       = 1'b1;
        ready_out = 1'b0;
        cycle();
        rst       = 1'b0;
        ready_out = 1'b1;
        chk("mid_rst_valid_out", {31'b0, valid_out}, 32'd0);
        chk("mid_rst_ready_in", {31'b0, ready_in}, 32'd1);
        chk("mid_rst_data_out", data_out, 32'd0);
        chk("mid_rst_index_out", {30'b0, index_out}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("post_rst_quiet", {31'b0, valid_out}, 32'd0);
        end
        chk("final_sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL global_timeout: simulation did not finish");
    end

endmodule
